// File: rtl/load_data_packer.sv
// load_data_packer: unpacks returned memory words into vector elements (8/16/32b), one per cycle.
// Revision 1.0
`default_nettype none

module load_data_packer (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        start_i,
  input  logic [4:0]  vl_i,
  input  logic [1:0]  vsew_i,
  input  logic        zero_stride_i,
  input  logic [3:0]  be_i,
  input  logic        be_valid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        next_cycle_o,
  output logic        el_valid_o,
  input  logic        el_ready_i,
  output logic [4:0]  el_idx_o,
  output logic [31:0] el_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_EMIT      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [1:0] c_SEW8    = 2'b00;
  localparam logic [1:0] c_SEW16   = 2'b01;
  localparam logic [1:0] c_SEW_BAD = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_vsew;
  logic        r_zs;
  logic [4:0]  r_idx;
  logic [4:0]  r_rem;
  logic        r_be_pend;
  logic [3:0]  r_be_pend_val;
  logic [3:0]  r_wbe;
  logic [31:0] r_wdata;
  logic        r_err;

  logic [3:0]  w_grp_mask;
  logic [31:0] w_el_data;
  logic        w_has_el;
  logic [3:0]  w_be_after;
  logic        w_start_ok;
  logic        w_capture;
  logic        w_accept;
  logic        w_next_cycle;
  logic        w_err;

  // A 16b/32b group only counts when its lowest lane is enabled.
  function automatic logic f_has_group(input logic [1:0] sew, input logic [3:0] be);
    logic r;
    case (sew)
      c_SEW8:  r = |be;
      c_SEW16: r = be[0] | be[2];
      default: r = be[0];
    endcase
    return r;
  endfunction

  always_comb begin
    w_grp_mask = 4'b0000;
    w_el_data  = 32'd0;
    case (r_vsew)
      c_SEW8: begin
        if (r_wbe[0]) begin
          w_grp_mask = 4'b0001;
          w_el_data  = {24'd0, r_wdata[7:0]};
        end else if (r_wbe[1]) begin
          w_grp_mask = 4'b0010;
          w_el_data  = {24'd0, r_wdata[15:8]};
        end else if (r_wbe[2]) begin
          w_grp_mask = 4'b0100;
          w_el_data  = {24'd0, r_wdata[23:16]};
        end else if (r_wbe[3]) begin
          w_grp_mask = 4'b1000;
          w_el_data  = {24'd0, r_wdata[31:24]};
        end
      end
      c_SEW16: begin
        if (r_wbe[0]) begin
          w_grp_mask = 4'b0011;
          w_el_data  = {16'd0, r_wdata[15:0]};
        end else if (r_wbe[2]) begin
          w_grp_mask = 4'b1100;
          w_el_data  = {16'd0, r_wdata[31:16]};
        end
      end
      default: begin
        if (r_wbe[0]) begin
          w_grp_mask = 4'b1111;
          w_el_data  = r_wdata;
        end
      end
    endcase
  end

  assign w_has_el   = |w_grp_mask;
  // Broadcast loads reuse the same group for every element.
  assign w_be_after = r_zs ? r_wbe : (r_wbe & ~w_grp_mask);

  always_comb begin
    w_state_nxt  = r_state;
    w_start_ok   = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    w_next_cycle = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (vsew_i == c_SEW_BAD) begin
            w_err = 1'b1;
          end else if (vl_i == 5'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_start_ok  = 1'b1;
            w_state_nxt = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        if (mem_rvalid_i && r_be_pend) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!w_has_el) begin
          w_next_cycle = 1'b1;
          w_state_nxt  = S_WAIT_DATA;
        end else if (el_ready_i) begin
          w_accept = 1'b1;
          if (r_rem == 5'd1) begin
            w_state_nxt = S_DONE;
          end else if (!f_has_group(r_vsew, w_be_after)) begin
            w_next_cycle = 1'b1;
            w_state_nxt  = S_WAIT_DATA;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (mem_rvalid_i && !w_capture) begin
      w_err = 1'b1;
    end
    if (be_valid_i && r_be_pend && !w_capture) begin
      w_err = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_vsew        <= 2'b00;
      r_zs          <= 1'b0;
      r_idx         <= 5'd0;
      r_rem         <= 5'd0;
      r_be_pend     <= 1'b0;
      r_be_pend_val <= 4'b0000;
      r_wbe         <= 4'b0000;
      r_wdata       <= 32'd0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_start_ok) begin
        r_vsew <= vsew_i;
        r_zs   <= zero_stride_i;
        r_idx  <= 5'd0;
        r_rem  <= vl_i;
      end
      if (w_capture) begin
        r_wdata <= mem_rdata_i;
        r_wbe   <= r_be_pend_val;
      end else if (w_accept) begin
        r_wbe <= w_be_after;
      end
      // A new request's BE may arrive in the same cycle the old one is consumed.
      if (be_valid_i) begin
        r_be_pend     <= 1'b1;
        r_be_pend_val <= be_i;
      end else if (w_capture) begin
        r_be_pend <= 1'b0;
      end
      if (w_accept) begin
        r_idx <= r_idx + 5'd1;
        r_rem <= r_rem - 5'd1;
      end
    end
  end

  assign el_valid_o   = (r_state == S_EMIT) && w_has_el;
  assign el_data_o    = el_valid_o ? w_el_data : 32'd0;
  assign el_idx_o     = r_idx;
  assign next_cycle_o = w_next_cycle;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign error_o      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_load_data_packer.sv
// tb_load_data_packer: directed table-driven checks plus hand sequences for load_data_packer.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_load_data_packer;

  logic        clk_i;
  logic        n_rst_i;
  logic        start_i;
  logic [4:0]  vl_i;
  logic [1:0]  vsew_i;
  logic        zero_stride_i;
  logic [3:0]  be_i;
  logic        be_valid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;
  logic        next_cycle_o;
  logic        el_valid_o;
  logic        el_ready_i;
  logic [4:0]  el_idx_o;
  logic [31:0] el_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  vsew;
    logic [4:0]  vl;
    logic        zs;
    logic [3:0]  be;
    logic [31:0] word;
    logic [31:0] exp [4];
  } vec_t;

  vec_t vecs [7];

  load_data_packer u_dut (
    .clk_i         (clk_i),
    .n_rst_i       (n_rst_i),
    .start_i       (start_i),
    .vl_i          (vl_i),
    .vsew_i        (vsew_i),
    .zero_stride_i (zero_stride_i),
    .be_i          (be_i),
    .be_valid_i    (be_valid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .next_cycle_o  (next_cycle_o),
    .el_valid_o    (el_valid_o),
    .el_ready_i    (el_ready_i),
    .el_idx_o      (el_idx_o),
    .el_data_o     (el_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_load(input logic [1:0] sew, input logic [4:0] vl, input logic zs);
    start_i       = 1'b1;
    vsew_i        = sew;
    vl_i          = vl;
    zero_stride_i = zs;
    tick();
    start_i       = 1'b0;
  endtask

  task automatic give_be(input logic [3:0] be);
    be_valid_i = 1'b1;
    be_i       = be;
    tick();
    be_valid_i = 1'b0;
  endtask

  task automatic give_word(input logic [31:0] w);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = w;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] sew, input logic [4:0] vl, input logic zs,
                              input logic [3:0] be, input logic [31:0] w,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.vsew = sew; v.vl = vl; v.zs = zs; v.be = be; v.word = w;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  // Single-word load: every element comes from one returned word, so no next_cycle_o.
  task automatic run_vec(input vec_t v);
    el_ready_i = 1'b1;
    start_load(v.vsew, v.vl, v.zs);
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    give_be(v.be);
    give_word(v.word);
    for (int i = 0; i < int'(v.vl); i++) begin
      chk("el_valid", {31'd0, el_valid_o}, 32'd1);
      chk("el_idx", {27'd0, el_idx_o}, 32'(i));
      chk("el_data", el_data_o, v.exp[i]);
      chk("no_next_cycle", {31'd0, next_cycle_o}, 32'd0);
      tick();
    end
    chk("done_pulse", {31'd0, done_o}, 32'd1);
    tick();
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
    chk("done_cleared", {31'd0, done_o}, 32'd0);
    chk("no_error", {31'd0, error_o}, 32'd0);
  endtask

  initial begin
    n_rst_i       = 1'b0;
    start_i       = 1'b0;
    vl_i          = 5'd0;
    vsew_i        = 2'b00;
    zero_stride_i = 1'b0;
    be_i          = 4'b0000;
    be_valid_i    = 1'b0;
    mem_rdata_i   = 32'd0;
    mem_rvalid_i  = 1'b0;
    el_ready_i    = 1'b1;

    vecs[0] = mk(2'b00, 5'd4, 1'b0, 4'hF, 32'hDDCCBBAA, 32'hAA, 32'hBB, 32'hCC, 32'hDD);
    vecs[1] = mk(2'b01, 5'd2, 1'b1, 4'hC, 32'hBEEF1234, 32'h0000BEEF, 32'h0000BEEF, 32'd0, 32'd0);
    vecs[2] = mk(2'b01, 5'd2, 1'b0, 4'hF, 32'hA5A55A5A, 32'h00005A5A, 32'h0000A5A5, 32'd0, 32'd0);
    vecs[3] = mk(2'b10, 5'd1, 1'b0, 4'hF, 32'h87654321, 32'h87654321, 32'd0, 32'd0, 32'd0);
    vecs[4] = mk(2'b00, 5'd2, 1'b0, 4'hA, 32'h44332211, 32'h22, 32'h44, 32'd0, 32'd0);
    vecs[5] = mk(2'b00, 5'd3, 1'b1, 4'h4, 32'h11C32244, 32'hC3, 32'hC3, 32'hC3, 32'd0);
    vecs[6] = mk(2'b00, 5'd2, 1'b0, 4'hF, 32'h0A0B0C0D, 32'h0D, 32'h0C, 32'd0, 32'd0);

    tick();
    tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_error", {31'd0, error_o}, 32'd0);
    chk("rst_el_valid", {31'd0, el_valid_o}, 32'd0);
    chk("rst_next_cycle", {31'd0, next_cycle_o}, 32'd0);
    chk("rst_el_idx", {27'd0, el_idx_o}, 32'd0);
    chk("rst_el_data", el_data_o, 32'd0);
    n_rst_i = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k]);
    end

    // Strided 8b load spanning two words.
    el_ready_i = 1'b1;
    start_load(2'b00, 5'd3, 1'b0);
    give_be(4'b0101);
    give_word(32'h44332211);
    chk("s2_idx0", {27'd0, el_idx_o}, 32'd0);
    chk("s2_data0", el_data_o, 32'h11);
    chk("s2_next0", {31'd0, next_cycle_o}, 32'd0);
    tick();
    chk("s2_idx1", {27'd0, el_idx_o}, 32'd1);
    chk("s2_data1", el_data_o, 32'h33);
    chk("s2_next1", {31'd0, next_cycle_o}, 32'd1);
    tick();
    chk("s2_wait_valid", {31'd0, el_valid_o}, 32'd0);
    chk("s2_wait_busy", {31'd0, busy_o}, 32'd1);
    give_be(4'b0001);
    give_word(32'h88776655);
    chk("s2_idx2", {27'd0, el_idx_o}, 32'd2);
    chk("s2_data2", el_data_o, 32'h55);
    chk("s2_next2", {31'd0, next_cycle_o}, 32'd0);
    tick();
    chk("s2_done", {31'd0, done_o}, 32'd1);
    tick();

    // 32b load with back-pressure on the first element.
    el_ready_i = 1'b0;
    start_load(2'b10, 5'd2, 1'b0);
    give_be(4'hF);
    give_word(32'hCAFEF00D);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", {31'd0, el_valid_o}, 32'd1);
      chk("bp_idx", {27'd0, el_idx_o}, 32'd0);
      chk("bp_data", el_data_o, 32'hCAFEF00D);
      chk("bp_next", {31'd0, next_cycle_o}, 32'd0);
      tick();
    end
    el_ready_i = 1'b1;
    #1;
    chk("bp_accept_next", {31'd0, next_cycle_o}, 32'd1);
    chk("bp_accept_idx", {27'd0, el_idx_o}, 32'd0);
    tick();
    chk("bp_wait_valid", {31'd0, el_valid_o}, 32'd0);
    give_be(4'hF);
    give_word(32'h0BADBEEF);
    chk("bp_idx1", {27'd0, el_idx_o}, 32'd1);
    chk("bp_data1", el_data_o, 32'h0BADBEEF);
    chk("bp_next1", {31'd0, next_cycle_o}, 32'd0);
    tick();
    chk("bp_done", {31'd0, done_o}, 32'd1);
    tick();

    // Protocol errors while idle.
    give_word(32'h12345678);
    chk("idle_rvalid_err", {31'd0, error_o}, 32'd1);
    chk("idle_rvalid_busy", {31'd0, busy_o}, 32'd0);
    tick();
    chk("idle_err_clear", {31'd0, error_o}, 32'd0);
    start_load(2'b11, 5'd4, 1'b0);
    chk("bad_sew_err", {31'd0, error_o}, 32'd1);
    chk("bad_sew_busy", {31'd0, busy_o}, 32'd0);
    tick();
    chk("bad_sew_err_clear", {31'd0, error_o}, 32'd0);

    // Zero-length load goes straight to DONE.
    start_load(2'b00, 5'd0, 1'b0);
    chk("vl0_done", {31'd0, done_o}, 32'd1);
    chk("vl0_busy", {31'd0, busy_o}, 32'd1);
    tick();
    chk("vl0_idle", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset in the middle of emission.
    el_ready_i = 1'b1;
    start_load(2'b00, 5'd4, 1'b0);
    give_be(4'hF);
    give_word(32'hDDCCBBAA);
    tick();
    chk("mid_idx1", {27'd0, el_idx_o}, 32'd1);
    n_rst_i = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, el_valid_o}, 32'd0);
    chk("mid_rst_idx", {27'd0, el_idx_o}, 32'd0);
    chk("mid_rst_data", el_data_o, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    #2;
    n_rst_i = 1'b1;
    tick();
    run_vec(vecs[0]);

    // Second BE while one is still pending.
    give_be(4'h1);
    chk("be_single_noerr", {31'd0, error_o}, 32'd0);
    give_be(4'h3);
    chk("be_double_err", {31'd0, error_o}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
